tsip_tx_scheduler: RTL and testbench

- Shares the single Thunderbolt UART transmitter between two TSIP packet sources: req 0 = power-up configuration sequencer (8E-A2, 8E-A5), req 1 = host/register-map command path.
- Each source streams only the packet body (ID byte onward). This block adds DLE framing, doubles payload DLE bytes, appends DLE ETX, and paces bytes against the uart_tx done handshake.
- Sits between the packet sources and uart_tx inside the Thunderbolt interface.

---
 rtl/tsip_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_tsip_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsip_tx_scheduler.sv
// Arbitrates two TSIP body streams onto one UART: adds DLE framing, DLE stuffing and DLE ETX trailer.
// Grant to first o_tx_dv is 1 cycle; each byte waits for i_tx_done; sources are paced by o_req_ready pulses.
module tsip_tx_scheduler #(
    parameter int TIMEOUT_CLKS = 20000,
    parameter int MAX_BODY     = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req_valid,
    input  logic [7:0] i_req_byte0,
    input  logic [7:0] i_req_byte1,
    input  logic [1:0] i_req_last,
    output logic [1:0] o_req_ready,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_pkt_done,
    output logic       o_abort,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_FETCH, S_SEND, S_STUFF, S_EOF_DLE, S_EOF_ETX, S_CLOSE
    } state_t;

    localparam logic [7:0]  DLE      = 8'h10;
    localparam logic [7:0]  ETX      = 8'h03;
    localparam logic [14:0] TOUT_LIM = 15'(TIMEOUT_CLKS);
    localparam logic [6:0]  BODY_LIM = 7'(MAX_BODY);

    state_t      state_q, state_d;
    logic        wait_q;      // byte handed to uart_tx, waiting for its done pulse
    logic        sel_q;
    logic        rr_last_q;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [6:0]  cnt_q;
    logic [14:0] tout_q;
    logic        abort_q;

    logic        start, grant_sel, accept, fetch_abort, advance;
    logic        src_vld, src_last;
    logic [7:0]  src_byte;

    assign src_vld  = i_req_valid[sel_q];
    assign src_last = i_req_last[sel_q];
    assign src_byte = sel_q ? i_req_byte1 : i_req_byte0;
    assign advance  = wait_q && i_tx_done;

    assign o_busy  = (state_q != S_IDLE);
    assign o_grant = (state_q == S_IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        grant_sel   = sel_q;
        accept      = 1'b0;
        fetch_abort = 1'b0;
        o_req_ready = 2'b00;
        o_pkt_done  = 1'b0;
        o_abort     = 1'b0;
        o_tx_dv     = 1'b0;
        o_tx_byte   = DLE;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid != 2'b00) begin
                    start     = 1'b1;
                    grant_sel = (i_req_valid == 2'b11) ? ~rr_last_q : i_req_valid[1];
                    state_d   = S_SOF;
                end
            end
            S_SOF: begin
                o_tx_dv = !wait_q;
                if (advance) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (src_vld) begin
                    if (cnt_q == BODY_LIM) begin
                        fetch_abort = 1'b1;
                        state_d     = S_EOF_DLE;
                    end else begin
                        accept      = 1'b1;
                        o_req_ready = sel_q ? 2'b10 : 2'b01;
                        state_d     = S_SEND;
                    end
                end else if (tout_q == TOUT_LIM) begin
                    fetch_abort = 1'b1;
                    state_d     = S_EOF_DLE;
                end
            end
            S_SEND: begin
                o_tx_dv   = !wait_q;
                o_tx_byte = byte_q;
                if (advance) begin
                    if (byte_q == DLE) state_d = S_STUFF;
                    else               state_d = last_q ? S_EOF_DLE : S_FETCH;
                end
            end
            S_STUFF: begin
                o_tx_dv = !wait_q;
                if (advance) state_d = last_q ? S_EOF_DLE : S_FETCH;
            end
            S_EOF_DLE: begin
                o_tx_dv = !wait_q;
                if (advance) state_d = S_EOF_ETX;
            end
            S_EOF_ETX: begin
                o_tx_dv   = !wait_q;
                o_tx_byte = ETX;
                if (advance) state_d = S_CLOSE;
            end
            S_CLOSE: begin
                o_abort    = abort_q;
                o_pkt_done = !abort_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 1'b0;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
            byte_q    <= 8'h00;
            last_q    <= 1'b0;
            cnt_q     <= 7'd0;
            tout_q    <= 15'd0;
            abort_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (o_tx_dv)      wait_q <= 1'b1;
            else if (advance) wait_q <= 1'b0;
            if (start) begin
                sel_q   <= grant_sel;
                cnt_q   <= 7'd0;
                abort_q <= 1'b0;
            end
            if (accept) begin
                byte_q <= src_byte;
                last_q <= src_last;
                cnt_q  <= cnt_q + 7'd1;
            end
            if (fetch_abort) abort_q <= 1'b1;
            // Idle-wait counter only runs while the granted source has nothing to offer.
            if (state_q == S_FETCH && !src_vld) tout_q <= tout_q + 15'd1;
            else                                tout_q <= 15'd0;
            if (state_q == S_CLOSE) rr_last_q <= sel_q;
        end
    end

endmodule

// File: tb/tb_tsip_tx_scheduler.sv
// Bench for tsip_tx_scheduler: source drivers, a uart_tx responder and a frame-level reference model.
module tb_tsip_tx_scheduler;

    localparam int TOUT   = 300;
    localparam int MAXB   = 64;
    localparam int BUDGET = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_byte0 = 8'h00;
    logic [7:0] req_byte1 = 8'h00;
    logic [1:0] req_last = 2'b00;
    logic [1:0] req_ready, grant;
    logic       busy, pkt_done, abort_p, tx_dv;
    logic [7:0] tx_byte;
    logic       tx_done = 1'b0;

    always #5 clk = ~clk;

    tsip_tx_scheduler #(.TIMEOUT_CLKS(TOUT), .MAX_BODY(MAXB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_byte0(req_byte0), .i_req_byte1(req_byte1),
        .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant),
        .o_busy(busy), .o_pkt_done(pkt_done), .o_abort(abort_p),
        .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_done(tx_done)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [7:0] b; logic l; } ent_t;

    ent_t       sq0[$], sq1[$];
    logic [7:0] exp_s[$], obs_s[$];
    logic [1:0] exp_g[$], obs_g[$];
    int exp_done = 0, exp_abort = 0, n_done = 0, n_abort = 0;
    int viol_rdy = 0, viol_dv = 0, viol_hold = 0;
    int rr_last = 1;
    int n_checks = 0, n_errors = 0;

    logic       pend = 1'b0;
    int         cd = 0;
    logic [7:0] cur = 8'h00;
    logic [1:0] prev_g = 2'b00;
    logic [1:0] rdy = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Sources present the head of their queue; a byte leaves the queue once it was acked.
    initial begin
        forever begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy[0] && sq0.size() > 0) void'(sq0.pop_front());
            if (rdy[1] && sq1.size() > 0) void'(sq1.pop_front());
            req_valid = {sq1.size() > 0, sq0.size() > 0};
            if (sq0.size() > 0) begin req_byte0 = sq0[0].b; req_last[0] = sq0[0].l; end
            else begin req_byte0 = 8'h00; req_last[0] = 1'b0; end
            if (sq1.size() > 0) begin req_byte1 = sq1[0].b; req_last[1] = sq1[0].l; end
            else begin req_byte1 = 8'h00; req_last[1] = 1'b0; end
        end
    end

    // uart_tx responder plus protocol monitor; leftover bytes of a closed packet are withdrawn.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                pend   = 1'b0;
                prev_g = 2'b00;
            end else begin
                if (pend) begin
                    if (tx_dv) viol_dv++;
                    if (tx_byte !== cur) viol_hold++;
                    if (cd == 0) begin tx_done = 1'b1; pend = 1'b0; end
                    else cd--;
                end else if (tx_dv) begin
                    pend = 1'b1;
                    cur  = tx_byte;
                    obs_s.push_back(tx_byte);
                    cd   = $urandom_range(0, 4);
                end
                if ((req_ready & ~grant) != 2'b00) viol_rdy++;
                if (prev_g == 2'b00 && grant != 2'b00) obs_g.push_back(grant);
                prev_g = grant;
                if (pkt_done) n_done++;
                if (abort_p)  n_abort++;
                if (pkt_done || abort_p) begin
                    if (grant[0]) sq0.delete();
                    if (grant[1]) sq1.delete();
                end
            end
        end
    end

    function automatic logic [7:0] rnd_byte();
        return ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom_range(0, 255));
    endfunction

    task automatic load(input int src, input bq_t body, input bit with_last);
        ent_t e;
        foreach (body[i]) begin
            e.b = body[i];
            e.l = with_last && (i == body.size() - 1);
            if (src == 0) sq0.push_back(e); else sq1.push_back(e);
        end
    endtask

    // Expected wire image of one packet: DLE, body with DLE doubled, DLE ETX.
    task automatic frame(input int src, input bq_t body, input bit aborted);
        exp_s.push_back(8'h10);
        foreach (body[i]) begin
            exp_s.push_back(body[i]);
            if (body[i] == 8'h10) exp_s.push_back(8'h10);
        end
        exp_s.push_back(8'h10);
        exp_s.push_back(8'h03);
        exp_g.push_back(src == 0 ? 2'b01 : 2'b10);
        if (aborted) exp_abort++; else exp_done++;
        rr_last = src;
    endtask

    task automatic dual(input bq_t p0, input bq_t p1);
        load(0, p0, 1'b1);
        load(1, p1, 1'b1);
        if (rr_last == 1) begin frame(0, p0, 1'b0); frame(1, p1, 1'b0); end
        else              begin frame(1, p1, 1'b0); frame(0, p0, 1'b0); end
    endtask

    task automatic run_check(input string tag);
        int k = 0;
        while (!(sq0.size() == 0 && sq1.size() == 0 && !busy &&
                 (n_done + n_abort) == (exp_done + exp_abort)) && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_settle"}, 32'(k < BUDGET), 1);
        chk({tag, "_len"}, obs_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), obs_s[i], exp_s[i]);
        chk({tag, "_ngrant"}, obs_g.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < obs_g.size(); i++)
            chk($sformatf("%s_g%0d", tag, i), obs_g[i], exp_g[i]);
        chk({tag, "_done"}, n_done, exp_done);
        chk({tag, "_abort"}, n_abort, exp_abort);
        obs_s.delete(); exp_s.delete(); obs_g.delete(); exp_g.delete();
        n_done = 0; n_abort = 0; exp_done = 0; exp_abort = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, req_ready, 2'b00);
        chk({tag, "_grant"}, grant, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, pkt_done, 1'b0);
        chk({tag, "_abort"}, abort_p, 1'b0);
        chk({tag, "_dv"}, tx_dv, 1'b0);
        chk({tag, "_byte"}, tx_byte, 8'h10);
    endtask

    initial begin
        bq_t p, q;
        int  k, ndv;
        bit  seen;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous request straight after reset: source 0 wins first.
        p.delete(); p.push_back(8'h8E); p.push_back(8'hA5); p.push_back(8'h00);
        q.delete(); q.push_back(8'h8E); q.push_back(8'h42);
        dual(p, q);
        run_check("rr_a");

        p.delete(); p.push_back(8'h8E); p.push_back(8'hA2); p.push_back(8'h01);
        load(0, p, 1'b1); frame(0, p, 1'b0);
        run_check("s0_basic");

        // Source 0 was served last, so source 1 goes first now.
        p.delete(); p.push_back(8'h8E); p.push_back(8'hA2);
        q.delete(); q.push_back(8'h8E); q.push_back(8'h10); q.push_back(8'h05);
        dual(p, q);
        run_check("rr_b");

        q.delete(); q.push_back(8'h8E); q.push_back(8'h10); q.push_back(8'h05);
        load(1, q, 1'b1); frame(1, q, 1'b0);
        run_check("s1_stuff");

        q.delete(); q.push_back(8'h8E); q.push_back(8'h10);
        load(1, q, 1'b1); frame(1, q, 1'b0);
        run_check("s1_last_dle");

        q.delete(); q.push_back(8'h8E);
        load(1, q, 1'b0); frame(1, q, 1'b1);
        run_check("timeout");

        p.delete();
        for (int i = 0; i < MAXB + 1; i++) p.push_back(rnd_byte());
        load(0, p, 1'b0);
        void'(p.pop_back());
        frame(0, p, 1'b1);
        run_check("maxbody");

        for (int it = 0; it < 12; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            p.delete(); q.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) p.push_back(rnd_byte());
            for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(rnd_byte());
            if (mode == 0)      begin load(0, p, 1'b1); frame(0, p, 1'b0); end
            else if (mode == 1) begin load(1, q, 1'b1); frame(1, q, 1'b0); end
            else dual(p, q);
            run_check($sformatf("rnd%0d", it));
        end

        // Reset while the first body byte is on the wire.
        p.delete(); p.push_back(8'h8E); p.push_back(8'h11); p.push_back(8'h22); p.push_back(8'h33);
        load(0, p, 1'b1);
        k = 0; seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            seen = tx_dv && (tx_byte == 8'h8E);
        end
        chk("midsend_reach", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midsend_rst");
        sq0.delete();
        @(negedge clk);
        rst = 1'b0;
        rr_last = 1;
        ndv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_dv || busy) ndv++;
        end
        chk("midsend_quiet", ndv, 0);

        chk("viol_ready", viol_rdy, 0);
        chk("viol_dv_overlap", viol_dv, 0);
        chk("viol_byte_hold", viol_hold, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
